// File: rtl/fsx_frame_sig_if.sv
// Pixel-stream tap, arm request and signature result bundle for fsx_frame_sig.
// Latency: none; this is a pure signal grouping.
// Backpressure: none; the video side is observe-only and results are pulse/hold.
interface fsx_frame_sig_if;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        arm;
  logic        busy;
  logic        sig_valid;
  logic [15:0] sig_crc;
  logic [17:0] sig_pixels;
  logic [8:0]  sig_lines;
  logic        sig_err;
  logic [8:0]  err_line;

  // Video source / test controller side.
  modport master (
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, arm,
    input  busy, sig_valid, sig_crc, sig_pixels, sig_lines, sig_err, err_line
  );

  // Signature block side.
  modport slave (
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, arm,
    output busy, sig_valid, sig_crc, sig_pixels, sig_lines, sig_err, err_line
  );
endinterface

// File: rtl/fsx_frame_sig.sv
// Frame signature: CRC-16-CCITT, pixel and line count over one armed frame's active window.
// Latency: sig_valid pulses 2 cycles after the last active pixel is registered (or after an early vsync).
// Backpressure: none; passive observer, arm is dropped while busy. Macro FSX_SIG_LINECHK_EN adds err_line.
module fsx_frame_sig #(
  parameter int H_RES     = 480,
  parameter int V_RES     = 272,
  parameter int H_ACT_DLY = 2,    // 1..15
  parameter int V_ACT_DLY = 2,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0
) (
  input logic           vga_clk,
  input logic           nreset,
  fsx_frame_sig_if.slave bus
);

  localparam logic [17:0] PIX_TOTAL = 18'(H_RES * V_RES);
  localparam logic [17:0] H_LAST    = 18'(H_RES - 1);
  localparam logic [8:0]  LINES_TOT = 9'(V_RES);
  localparam logic [7:0]  VSKIP_N   = 8'(V_ACT_DLY);
  // The deassertion-edge cycle itself is the first porch cycle, hence the -1.
  localparam logic [3:0]  DLY_LD    = 4'(H_ACT_DLY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VS, S_VSYNC, S_VSKIP, S_HWAIT, S_PIXELS, S_LEND, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, hs_p_q, hs_p_d;
  logic        vs_q, vs_d, vs_p_q, vs_p_d;
  logic [7:0]  pix_q, pix_d;
  logic [15:0] crc_q, crc_d;
  logic [17:0] pix_cnt_q, pix_cnt_d;
  logic [17:0] line_px_q, line_px_d;
  logic [8:0]  line_cnt_q, line_cnt_d;
  logic [7:0]  hs_cnt_q, hs_cnt_d;
  logic [3:0]  dly_q, dly_d;
  logic        dly_run_q, dly_run_d;
  logic        sig_valid_q, sig_valid_d;
  logic [15:0] sig_crc_q, sig_crc_d;
  logic [17:0] sig_pix_q, sig_pix_d;
  logic [8:0]  sig_lines_q, sig_lines_d;
  logic        sig_err_q, sig_err_d;
`ifdef FSX_SIG_LINECHK_EN
  logic        line_err_q, line_err_d;
  logic [8:0]  err_idx_q, err_idx_d;
  logic [8:0]  sig_eline_q, sig_eline_d;
`endif

  logic hs_rise, hs_fall, vs_rise;

  // MSB-first CRC-16-CCITT byte step, no reflection.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Sync edges are taken on the registered, active-high syncs; pix_q shares that delay.
  assign hs_rise = hs_q & ~hs_p_q;
  assign hs_fall = ~hs_q & hs_p_q;
  assign vs_rise = vs_q & ~vs_p_q;

  // Next-state, counters and result capture.
  always_comb begin
    state_d     = state_q;
    hs_d        = H_POL ? bus.vga_hs : ~bus.vga_hs;
    vs_d        = V_POL ? bus.vga_vs : ~bus.vga_vs;
    hs_p_d      = hs_q;
    vs_p_d      = vs_q;
    pix_d       = {bus.vga_r, bus.vga_g, bus.vga_b};
    crc_d       = crc_q;
    pix_cnt_d   = pix_cnt_q;
    line_px_d   = line_px_q;
    line_cnt_d  = line_cnt_q;
    hs_cnt_d    = hs_cnt_q;
    dly_d       = dly_q;
    dly_run_d   = dly_run_q;
    sig_valid_d = 1'b0;
    sig_crc_d   = sig_crc_q;
    sig_pix_d   = sig_pix_q;
    sig_lines_d = sig_lines_q;
    sig_err_d   = sig_err_q;
`ifdef FSX_SIG_LINECHK_EN
    line_err_d  = line_err_q;
    err_idx_d   = err_idx_q;
    sig_eline_d = sig_eline_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.arm) state_d = S_WAIT_VS;
      end

      // Only a frame that starts after arming is signed.
      S_WAIT_VS: begin
        if (vs_rise) state_d = S_VSYNC;
      end

      S_VSYNC: begin
        crc_d      = 16'hFFFF;
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        hs_cnt_d   = '0;
`ifdef FSX_SIG_LINECHK_EN
        line_err_d = 1'b0;
        err_idx_d  = '0;
`endif
        if (!vs_q) state_d = S_VSKIP;
      end

      S_VSKIP: begin
        if (vs_rise) begin
          state_d = S_DONE;
        end else if (hs_rise) begin
          if (hs_cnt_q == VSKIP_N) begin
            state_d   = S_HWAIT;
            dly_run_d = 1'b0;
          end else begin
            hs_cnt_d = hs_cnt_q + 8'd1;
          end
        end
      end

      S_HWAIT: begin
        line_px_d = '0;
        if (vs_rise) begin
          state_d = S_DONE;
        end else if (dly_run_q) begin
          if (dly_q == 4'd1) begin
            state_d   = S_PIXELS;
            dly_run_d = 1'b0;
          end else begin
            dly_d = dly_q - 4'd1;
          end
        end else if (hs_fall) begin
          if (H_ACT_DLY <= 1) begin
            state_d = S_PIXELS;
          end else begin
            dly_d     = DLY_LD;
            dly_run_d = 1'b1;
          end
        end
      end

      S_PIXELS: begin
        if (vs_rise) begin
          state_d = S_DONE;
        end else if (hs_rise) begin
          // Line cut short by the next hsync: it still counts as a line.
          line_cnt_d = line_cnt_q + 9'd1;
          state_d    = S_HWAIT;
          dly_run_d  = 1'b0;
`ifdef FSX_SIG_LINECHK_EN
          if (line_px_q != 18'(H_RES) && !line_err_q) begin
            line_err_d = 1'b1;
            err_idx_d  = line_cnt_q;
          end
`endif
        end else begin
          crc_d     = crc_byte(crc_q, pix_q);
          pix_cnt_d = pix_cnt_q + 18'd1;
          line_px_d = line_px_q + 18'd1;
          if (line_px_q == H_LAST) begin
            line_cnt_d = line_cnt_q + 9'd1;
            state_d    = S_LEND;
          end
        end
      end

      S_LEND: begin
        if (vs_rise || line_cnt_q == LINES_TOT) begin
          state_d = S_DONE;
        end else if (hs_rise) begin
          state_d   = S_HWAIT;
          dly_run_d = 1'b0;
        end
      end

      S_DONE: begin
        sig_valid_d = 1'b1;
        sig_crc_d   = crc_q;
        sig_pix_d   = pix_cnt_q;
        sig_lines_d = line_cnt_q;
        sig_err_d   = (pix_cnt_q != PIX_TOTAL) || (line_cnt_q != LINES_TOT);
`ifdef FSX_SIG_LINECHK_EN
        sig_err_d   = sig_err_d || line_err_q;
        sig_eline_d = err_idx_q;
`endif
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, pipeline and result registers; reset drops any frame in progress.
  always_ff @(posedge vga_clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      hs_q        <= 1'b0;
      hs_p_q      <= 1'b0;
      vs_q        <= 1'b0;
      vs_p_q      <= 1'b0;
      pix_q       <= '0;
      crc_q       <= 16'hFFFF;
      pix_cnt_q   <= '0;
      line_px_q   <= '0;
      line_cnt_q  <= '0;
      hs_cnt_q    <= '0;
      dly_q       <= '0;
      dly_run_q   <= 1'b0;
      sig_valid_q <= 1'b0;
      sig_crc_q   <= '0;
      sig_pix_q   <= '0;
      sig_lines_q <= '0;
      sig_err_q   <= 1'b0;
`ifdef FSX_SIG_LINECHK_EN
      line_err_q  <= 1'b0;
      err_idx_q   <= '0;
      sig_eline_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hs_q        <= hs_d;
      hs_p_q      <= hs_p_d;
      vs_q        <= vs_d;
      vs_p_q      <= vs_p_d;
      pix_q       <= pix_d;
      crc_q       <= crc_d;
      pix_cnt_q   <= pix_cnt_d;
      line_px_q   <= line_px_d;
      line_cnt_q  <= line_cnt_d;
      hs_cnt_q    <= hs_cnt_d;
      dly_q       <= dly_d;
      dly_run_q   <= dly_run_d;
      sig_valid_q <= sig_valid_d;
      sig_crc_q   <= sig_crc_d;
      sig_pix_q   <= sig_pix_d;
      sig_lines_q <= sig_lines_d;
      sig_err_q   <= sig_err_d;
`ifdef FSX_SIG_LINECHK_EN
      line_err_q  <= line_err_d;
      err_idx_q   <= err_idx_d;
      sig_eline_q <= sig_eline_d;
`endif
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.sig_valid  = sig_valid_q;
  assign bus.sig_crc    = sig_crc_q;
  assign bus.sig_pixels = sig_pix_q;
  assign bus.sig_lines  = sig_lines_q;
  assign bus.sig_err    = sig_err_q;
`ifdef FSX_SIG_LINECHK_EN
  assign bus.err_line   = sig_eline_q;
`else
  assign bus.err_line   = '0;
`endif

endmodule

// File: tb/tb_fsx_frame_sig.sv
// Bench for fsx_frame_sig: two instances share one generated video stream.
// dut_a uses a 9x1 window (check-string CRC), dut_b a 16x8 window for frame scenarios.
// Expected signatures are queued when a frame is built and popped on sig_valid.
module tb_fsx_frame_sig;
  localparam int HB = 16;
  localparam int VB = 8;

  typedef struct packed {
    logic [15:0] crc;
    logic [17:0] px;
    logic [8:0]  lines;
    logic        err;
    logic [8:0]  eline;
  } exp_t;

  logic vga_clk;
  logic nreset;

  fsx_frame_sig_if bus_a ();
  fsx_frame_sig_if bus_b ();

  fsx_frame_sig #(.H_RES(9), .V_RES(1), .H_ACT_DLY(2), .V_ACT_DLY(2), .H_POL(1'b0), .V_POL(1'b0))
    dut_a (.vga_clk(vga_clk), .nreset(nreset), .bus(bus_a));

  fsx_frame_sig #(.H_RES(HB), .V_RES(VB), .H_ACT_DLY(2), .V_ACT_DLY(2), .H_POL(1'b0), .V_POL(1'b0))
    dut_b (.vga_clk(vga_clk), .nreset(nreset), .bus(bus_b));

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t pop_a, pop_b;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] arm_req  = 2'b00;
  logic [1:0] busy_chk = 2'b00;
  int   rst_cnt = 0;
  logic rst_chk = 1'b0;

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Bit-serial CRC-16-CCITT reference (LFSR fed one input bit at a time).
  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [7:0] rnd();
    return 8'($urandom);
  endfunction

  task automatic reset_checks();
    chk("rst_a_busy",   32'(bus_a.busy), 0);
    chk("rst_a_valid",  32'(bus_a.sig_valid), 0);
    chk("rst_a_crc",    32'(bus_a.sig_crc), 0);
    chk("rst_b_busy",   32'(bus_b.busy), 0);
    chk("rst_b_valid",  32'(bus_b.sig_valid), 0);
    chk("rst_b_crc",    32'(bus_b.sig_crc), 0);
    chk("rst_b_pixels", 32'(bus_b.sig_pixels), 0);
    chk("rst_b_lines",  32'(bus_b.sig_lines), 0);
    chk("rst_b_err",    32'(bus_b.sig_err), 0);
    chk("rst_b_eline",  32'(bus_b.err_line), 0);
  endtask

  // One pixel clock of video on both buses; hs_a/vs_a are active-high here, driven active-low.
  task automatic drive_cycle(input logic hs_a, input logic vs_a, input logic [7:0] px);
    @(negedge vga_clk);
    if (busy_chk[0]) chk("a_busy_after_arm", 32'(bus_a.busy), 1);
    if (busy_chk[1]) chk("b_busy_after_arm", 32'(bus_b.busy), 1);
    busy_chk = 2'b00;
    if (rst_chk) begin
      reset_checks();
      rst_chk = 1'b0;
    end
    if (rst_cnt > 0) begin
      nreset = 1'b0;
      rst_cnt--;
      if (rst_cnt == 0) rst_chk = 1'b1;
    end else begin
      nreset = 1'b1;
    end
    {bus_a.vga_r, bus_a.vga_g, bus_a.vga_b} = px;
    {bus_b.vga_r, bus_b.vga_g, bus_b.vga_b} = px;
    bus_a.vga_hs = ~hs_a;
    bus_b.vga_hs = ~hs_a;
    bus_a.vga_vs = ~vs_a;
    bus_b.vga_vs = ~vs_a;
    bus_a.arm    = arm_req[0];
    bus_b.arm    = arm_req[1];
    busy_chk     = arm_req;
    arm_req      = 2'b00;
  endtask

  task automatic blank_line(input logic vs_a);
    drive_cycle(1'b1, vs_a, rnd());
    drive_cycle(1'b1, vs_a, rnd());
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, vs_a, rnd());
  endtask

  // mode: 0 zeros, 1 random, 2 "123456789...". push_sel/arm_sel: 0 none, 1 dut_a, 2 dut_b.
  // arm_line: -2 none, -1 before vsync, >=0 at that active line. short_ln/rst_line: -1 none.
  task automatic send_frame(input int h, input int v, input int mode, input int nlines,
                            input int short_ln, input int short_px, input int push_sel,
                            input int arm_sel, input int arm_line, input int rst_line);
    logic [7:0]  dq[$];
    logic [15:0] c;
    logic [7:0]  b;
    exp_t        e;
    int          n;
    int          npx;
    c   = 16'hFFFF;
    npx = 0;
    e   = '0;
    for (int l = 0; l < nlines; l++) begin
      n = (l == short_ln) ? short_px : h;
      for (int p = 0; p < n; p++) begin
        case (mode)
          0:       b = 8'h00;
          1:       b = rnd();
          default: b = 8'h31 + 8'(p);
        endcase
        dq.push_back(b);
        c = model_crc(c, b);
        npx++;
      end
    end
    e.crc   = c;
    e.px    = 18'(npx);
    e.lines = 9'(nlines);
    e.err   = (npx != h * v) || (nlines != v);
`ifdef FSX_SIG_LINECHK_EN
    if (short_ln >= 0 && short_ln < nlines) begin
      e.err   = 1'b1;
      e.eline = 9'(short_ln);
    end
`endif
    if (push_sel == 1) exp_a.push_back(e);
    if (push_sel == 2) exp_b.push_back(e);

    if (arm_line == -1) arm_req = 2'(arm_sel);
    drive_cycle(1'b0, 1'b0, rnd());
    drive_cycle(1'b0, 1'b0, rnd());
    drive_cycle(1'b0, 1'b1, rnd());
    drive_cycle(1'b0, 1'b1, rnd());
    for (int i = 0; i < 2; i++) blank_line(1'b1);
    drive_cycle(1'b0, 1'b0, rnd());
    drive_cycle(1'b0, 1'b0, rnd());
    for (int i = 0; i < 2; i++) blank_line(1'b0);
    for (int l = 0; l < nlines; l++) begin
      if (l == arm_line) arm_req = 2'(arm_sel);
      drive_cycle(1'b1, 1'b0, rnd());
      drive_cycle(1'b1, 1'b0, rnd());
      drive_cycle(1'b0, 1'b0, rnd());
      drive_cycle(1'b0, 1'b0, rnd());
      n = (l == short_ln) ? short_px : h;
      for (int p = 0; p < n; p++) begin
        if (l == rst_line && p == 3) rst_cnt = 3;
        drive_cycle(1'b0, 1'b0, dq.pop_front());
      end
      if (l != short_ln) begin
        drive_cycle(1'b0, 1'b0, rnd());
        drive_cycle(1'b0, 1'b0, rnd());
      end
    end
    if (nlines == v) blank_line(1'b0);
  endtask

  // Result monitors: every sig_valid must match the oldest queued expectation.
  always @(negedge vga_clk) begin
    if (bus_a.sig_valid === 1'b1) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        pop_a = exp_a.pop_front();
        chk("a_crc",    32'(bus_a.sig_crc),    32'(pop_a.crc));
        chk("a_pixels", 32'(bus_a.sig_pixels), 32'(pop_a.px));
        chk("a_lines",  32'(bus_a.sig_lines),  32'(pop_a.lines));
        chk("a_err",    32'(bus_a.sig_err),    32'(pop_a.err));
        chk("a_eline",  32'(bus_a.err_line),   32'(pop_a.eline));
      end
    end
  end

  always @(negedge vga_clk) begin
    if (bus_b.sig_valid === 1'b1) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        pop_b = exp_b.pop_front();
        chk("b_crc",    32'(bus_b.sig_crc),    32'(pop_b.crc));
        chk("b_pixels", 32'(bus_b.sig_pixels), 32'(pop_b.px));
        chk("b_lines",  32'(bus_b.sig_lines),  32'(pop_b.lines));
        chk("b_err",    32'(bus_b.sig_err),    32'(pop_b.err));
        chk("b_eline",  32'(bus_b.err_line),   32'(pop_b.eline));
      end
    end
  end

  initial begin
    nreset       = 1'b1;
    bus_a.vga_r  = '0; bus_a.vga_g = '0; bus_a.vga_b = '0;
    bus_b.vga_r  = '0; bus_b.vga_g = '0; bus_b.vga_b = '0;
    bus_a.vga_hs = 1'b1; bus_a.vga_vs = 1'b1; bus_a.arm = 1'b0;
    bus_b.vga_hs = 1'b1; bus_b.vga_vs = 1'b1; bus_b.arm = 1'b0;
    rst_cnt = 3;
    repeat (6) drive_cycle(1'b0, 1'b0, 8'h00);

    // Check string on the 9x1 instance: CRC must be 0x29B1.
    send_frame(9, 1, 2, 1, -1, 0, 1, 1, -1, -1);

    // Arm mid random frame (line 3): that frame is skipped, the following zero frame is signed.
    // A second arm inside the signed frame is ignored.
    send_frame(HB, VB, 1, VB, -1, 0, 0, 2, 3, -1);
    send_frame(HB, VB, 0, VB, -1, 0, 2, 2, 2, -1);

    // Clean random frame.
    send_frame(HB, VB, 1, VB, -1, 0, 2, 2, -1, -1);

    // Line 2 cut after 10 pixels by an early hsync.
    send_frame(HB, VB, 1, VB, 2, 10, 2, 2, -1, -1);

    // Only 6 lines before the next vsync; the next (unarmed) frame's vsync ends it.
    send_frame(HB, VB, 1, 6, -1, 0, 2, 2, -1, -1);
    send_frame(HB, VB, 1, VB, -1, 0, 0, 0, -2, -1);

    // Reset for 3 cycles inside line 4's active pixels: no result, outputs cleared.
    send_frame(HB, VB, 1, VB, -1, 0, 0, 2, -1, 4);

    // Re-arm after reset: full frame signed correctly.
    send_frame(HB, VB, 1, VB, -1, 0, 2, 2, -1, -1);

    repeat (30) drive_cycle(1'b0, 1'b0, 8'h00);
    chk("a_missing_valid", 32'(exp_a.size()), 0);
    chk("b_missing_valid", 32'(exp_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
